// File: rtl/div_arb_pkg.sv
// Shared types and defaults for the two-requester divider arbiter.
package div_arb_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 511;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_DIV0    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/div_arbiter_if.sv
// Requester-side and divider-side signals of the arbiter, bundled.
// slave: the arbiter. master: requesters plus the divider they share.
interface div_arbiter_if #(parameter int WIDTH = div_arb_pkg::DEF_WIDTH);

  logic             Req0;
  logic [WIDTH-1:0] Dividend0;
  logic [WIDTH-1:0] Divisor0;
  logic             Req1;
  logic [WIDTH-1:0] Dividend1;
  logic [WIDTH-1:0] Divisor1;
  logic             Ack0;
  logic             Ack1;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic [1:0]       Err;
  logic             DivReq;
  logic [WIDTH-1:0] DivA;
  logic [WIDTH-1:0] DivB;
  logic             DivDone;
  logic [WIDTH-1:0] DivQuotient;
  logic [WIDTH-1:0] DivRemainder;
  logic             Busy;

  modport slave (
    input  Req0, Dividend0, Divisor0, Req1, Dividend1, Divisor1,
    input  DivDone, DivQuotient, DivRemainder,
    output Ack0, Ack1, Quotient, Remainder, Err,
    output DivReq, DivA, DivB, Busy
  );

  modport master (
    output Req0, Dividend0, Divisor0, Req1, Dividend1, Divisor1,
    output DivDone, DivQuotient, DivRemainder,
    input  Ack0, Ack1, Quotient, Remainder, Err,
    input  DivReq, DivA, DivB, Busy
  );

endinterface

// File: rtl/div_watchdog.sv
// Cycle counter bounding how long the arbiter waits for the divider.
// expired flags the cycle in which the count has reached TIMEOUT-1.
module div_watchdog #(
  parameter int TIMEOUT = div_arb_pkg::DEF_TIMEOUT
) (
  input  logic Clock,
  input  logic nReset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // count up while enabled; clear has priority
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)     count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + CW'(1);
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one divider between two requesters.
//
// state   | meaning
// IDLE    | sample Req0/Req1, latch winner operands
// ISSUE   | DivReq pulse (suppressed for zero divisor), watchdog cleared
// WAIT    | wait for DivDone or watchdog expiry
// RESPOND | Ack to winner, pointer moves to the other requester
//
// A zero divisor still passes through ISSUE (without a DivReq) so the
// check runs on the latched divisor; its Ack lands two cycles after IDLE.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic         Clock,
  input  logic         nReset,
  div_arbiter_if.slave bus
);

  state_t           state, state_n;
  logic             ptr, ptr_n;
  logic             winner, winner_n;
  logic             pick1;
  logic [WIDTH-1:0] div_a, div_a_n, div_b, div_b_n;
  logic [WIDTH-1:0] quo, quo_n, rem, rem_n;
  logic [1:0]       err, err_n;
  logic             div_req, div_req_n;
  logic             ack0, ack0_n, ack1, ack1_n;
  logic             busy, busy_n;
  logic             wd_clear, wd_enable, wd_expired;

  div_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .Clock   (Clock),
    .nReset  (nReset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // state and registered outputs
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      winner  <= 1'b0;
      div_a   <= '0;
      div_b   <= '0;
      quo     <= '0;
      rem     <= '0;
      err     <= ERR_OK;
      div_req <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      winner  <= winner_n;
      div_a   <= div_a_n;
      div_b   <= div_b_n;
      quo     <= quo_n;
      rem     <= rem_n;
      err     <= err_n;
      div_req <= div_req_n;
      ack0    <= ack0_n;
      ack1    <= ack1_n;
      busy    <= busy_n;
    end
  end

  // next state and next values of every registered output
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    winner_n  = winner;
    div_a_n   = div_a;
    div_b_n   = div_b;
    quo_n     = quo;
    rem_n     = rem;
    err_n     = err;
    div_req_n = 1'b0;
    wd_clear  = 1'b0;
    wd_enable = 1'b0;
    pick1     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Req0 || bus.Req1) begin
          pick1     = bus.Req1 && (!bus.Req0 || ptr);
          winner_n  = pick1;
          div_a_n   = pick1 ? bus.Dividend1 : bus.Dividend0;
          div_b_n   = pick1 ? bus.Divisor1  : bus.Divisor0;
          div_req_n = (div_b_n != '0);
          state_n   = ISSUE;
        end
      end
      ISSUE: begin
        wd_clear = 1'b1;
        if (div_b == '0) begin
          quo_n   = '0;
          rem_n   = div_a;
          err_n   = ERR_DIV0;
          state_n = RESPOND;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        wd_enable = 1'b1;
        if (bus.DivDone) begin
          quo_n   = bus.DivQuotient;
          rem_n   = bus.DivRemainder;
          err_n   = ERR_OK;
          state_n = RESPOND;
        end else if (wd_expired) begin
          quo_n   = '0;
          rem_n   = '0;
          err_n   = ERR_TIMEOUT;
          state_n = RESPOND;
        end
      end
      RESPOND: begin
        ptr_n   = ~winner;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    ack0_n = (state != RESPOND) && (state_n == RESPOND) && !winner;
    ack1_n = (state != RESPOND) && (state_n == RESPOND) &&  winner;
    busy_n = (state_n != IDLE);
  end

  assign bus.Ack0      = ack0;
  assign bus.Ack1      = ack1;
  assign bus.Quotient  = quo;
  assign bus.Remainder = rem;
  assign bus.Err       = err;
  assign bus.DivReq    = div_req;
  assign bus.DivA      = div_a;
  assign bus.DivB      = div_b;
  assign bus.Busy      = busy;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed + randomized bench for div_arbiter with a behavioural divider
// and a transaction-level model of winner selection and results.
module tb_div_arbiter;
  import div_arb_pkg::*;

  localparam int W  = DEF_WIDTH;
  localparam int TO = DEF_TIMEOUT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_arbiter_if #(.WIDTH(W)) dif();

  div_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .Clock  (clk),
    .nReset (rst_n),
    .bus    (dif)
  );

  int total = 0;
  int bad   = 0;

  int divreq_cnt = 0, ack0_cnt = 0, ack1_cnt = 0;
  always @(negedge clk) begin
    if (dif.DivReq === 1'b1) divreq_cnt <= divreq_cnt + 1;
    if (dif.Ack0   === 1'b1) ack0_cnt   <= ack0_cnt + 1;
    if (dif.Ack1   === 1'b1) ack1_cnt   <= ack1_cnt + 1;
  end

  // divider model: Done div_lat cycles after the DivReq cycle
  bit hang     = 1'b0;
  int div_lat  = 4;
  int spur_req = 0;
  initial begin : divider_model
    int cnt;
    bit pend;
    int spur_seen;
    logic [W-1:0] a, b;
    cnt = 0; pend = 1'b0; spur_seen = 0; a = '0; b = '0;
    dif.DivDone = 1'b0; dif.DivQuotient = '0; dif.DivRemainder = '0;
    forever begin
      @(posedge clk); #1;
      dif.DivDone = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 1'b0;
          dif.DivDone = 1'b1;
          dif.DivQuotient = a / b;
          dif.DivRemainder = a % b;
        end
      end
      if (spur_req != spur_seen) begin
        spur_seen++;
        dif.DivDone = 1'b1;
        dif.DivQuotient = W'(8'hA5);
        dif.DivRemainder = W'(8'h5A);
      end
      if (dif.DivReq === 1'b1 && !hang) begin
        pend = 1'b1; cnt = div_lat; a = dif.DivA; b = dif.DivB;
      end
    end
  end

  logic [W-1:0] q_seen, r_seen, a_seen, b_seen;
  logic [1:0]   e_seen;
  int           ptr_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // cycle c = state after the c-th posedge following request drive
  task automatic wait_ack(input int limit, input bit drop, output int who,
                          output int ack_cyc, output int done_cyc, output int req_cyc);
    who = -1; ack_cyc = -1; done_cyc = -1; req_cyc = -1;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk); @(negedge clk);
      if (dif.DivReq === 1'b1 && req_cyc < 0) req_cyc = c;
      if (dif.DivDone === 1'b1) done_cyc = c;
      if (drop && c == 2) begin
        dif.Dividend0 = W'($urandom); dif.Divisor0 = W'($urandom);
        dif.Dividend1 = W'($urandom); dif.Divisor1 = W'($urandom);
      end
      if (dif.Ack0 === 1'b1 || dif.Ack1 === 1'b1) begin
        who = (dif.Ack1 === 1'b1) ? 1 : 0;
        ack_cyc = c;
        q_seen = dif.Quotient; r_seen = dif.Remainder; e_seen = dif.Err;
        a_seen = dif.DivA; b_seen = dif.DivB;
        if (drop) begin dif.Req0 = 1'b0; dif.Req1 = 1'b0; end
        break;
      end
    end
    chk("ack_within_budget", (who >= 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic do_txn(input string tag, input bit r0, input bit r1,
                        input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1, input int lat);
    int who, ac, dc, rc, w, d0, d1, dr;
    logic [W-1:0] ea, eb;
    repeat (2) @(negedge clk);
    #2;
    dr = divreq_cnt; d0 = ack0_cnt; d1 = ack1_cnt;
    div_lat = lat;
    dif.Dividend0 = a0; dif.Divisor0 = b0; dif.Dividend1 = a1; dif.Divisor1 = b1;
    dif.Req0 = r0; dif.Req1 = r1;
    w  = (r0 && r1) ? ptr_m : (r1 ? 1 : 0);
    ea = (w == 1) ? a1 : a0;
    eb = (w == 1) ? b1 : b0;
    wait_ack(TO + 20, 1'b1, who, ac, dc, rc);
    #2;
    chk({tag, "_winner"}, who, w);
    chk({tag, "_quot"}, q_seen, (eb == 0) ? '0 : ea / eb);
    chk({tag, "_rem"},  r_seen, (eb == 0) ? ea : ea % eb);
    chk({tag, "_err"},  e_seen, (eb == 0) ? ERR_DIV0 : ERR_OK);
    chk({tag, "_diva"}, a_seen, ea);
    chk({tag, "_divb"}, b_seen, eb);
    chk({tag, "_divreq_pulses"}, divreq_cnt - dr, (eb != 0) ? 1 : 0);
    chk({tag, "_other_ack"}, (w == 1) ? ack0_cnt - d0 : ack1_cnt - d1, 0);
    if (eb == 0) begin
      chk({tag, "_ack_cycle"}, ac, 2);
    end else begin
      chk({tag, "_divreq_cycle"}, rc, 1);
      chk({tag, "_ack_after_done"}, ac, dc + 1);
    end
    @(negedge clk);
    chk({tag, "_idle_busy"}, dif.Busy, 1'b0);
    ptr_m = 1 - w;
  endtask

  initial begin : main
    int who, ac, dc, rc, d0, d1, dr;
    bit r0, r1;
    int pick;
    logic [W-1:0] ra0, rb0, ra1, rb1;

    dif.Req0 = 1'b0; dif.Req1 = 1'b0;
    dif.Dividend0 = '0; dif.Divisor0 = '0; dif.Dividend1 = '0; dif.Divisor1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctl",  {dif.Ack0, dif.Ack1, dif.DivReq, dif.Busy, dif.Err}, 0);
    chk("reset_data", {dif.Quotient, dif.Remainder, dif.DivA, dif.DivB}, 0);
    rst_n = 1'b1;

    // round robin with both requests held for four transactions
    repeat (2) @(negedge clk);
    #2;
    dr = divreq_cnt;
    div_lat = 5;
    dif.Dividend0 = 8'd200; dif.Divisor0 = 8'd9;
    dif.Dividend1 = 8'd77;  dif.Divisor1 = 8'd5;
    dif.Req0 = 1'b1; dif.Req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ack(TO + 20, (i == 3), who, ac, dc, rc);
      chk("rr_order", who, i % 2);
      chk("rr_quot", q_seen, (i % 2 == 0) ? 8'd22 : 8'd15);
      chk("rr_rem",  r_seen, 8'd2);
    end
    #2;
    chk("rr_divreq_pulses", divreq_cnt - dr, 4);
    ptr_m = 0;

    do_txn("basic", 1'b1, 1'b0, 8'd100, 8'd7, 8'd0, 8'd0, 16);
    do_txn("div0",  1'b0, 1'b1, 8'd0, 8'd0, 8'd55, 8'd0, 4);

    // hung divider: watchdog timeout, then a stray Done is ignored
    hang = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    d0 = ack0_cnt; d1 = ack1_cnt;
    dif.Dividend0 = 8'd40; dif.Divisor0 = 8'd3; dif.Req0 = 1'b1;
    wait_ack(TO + 20, 1'b1, who, ac, dc, rc);
    chk("to_winner", who, 0);
    chk("to_err", e_seen, ERR_TIMEOUT);
    chk("to_data", {q_seen, r_seen}, 0);
    chk("to_divreq_cycle", rc, 1);
    chk("to_ack_cycle", ac, TO + 2);
    ptr_m = 1;
    hang = 1'b0;
    repeat (3) @(negedge clk);
    spur_req++;
    repeat (10) @(negedge clk);
    #2;
    chk("spurious_no_ack", (ack0_cnt - d0) + (ack1_cnt - d1), 1);
    do_txn("after_to", 1'b1, 1'b0, 8'd91, 8'd10, 8'd0, 8'd0, 3);

    // reset while waiting on the divider
    hang = 1'b1;
    repeat (2) @(negedge clk);
    dif.Dividend0 = 8'd90; dif.Divisor0 = 8'd4; dif.Req0 = 1'b1;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", dif.Busy, 1'b1);
    #2;
    d0 = ack0_cnt;
    dif.Req0 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl",  {dif.Ack0, dif.Ack1, dif.DivReq, dif.Busy, dif.Err}, 0);
    chk("mid_rst_data", {dif.Quotient, dif.Remainder, dif.DivA, dif.DivB}, 0);
    repeat (3) @(negedge clk);
    hang = 1'b0;
    ptr_m = 0;
    rst_n = 1'b1;
    do_txn("post_rst", 1'b0, 1'b1, 8'd0, 8'd0, 8'd33, 8'd6, 7);
    chk("aborted_no_ack0", ack0_cnt - d0, 0);

    do_txn("long", 1'b1, 1'b0, 8'd255, 8'd1, 8'd0, 8'd0, 260);

    for (int k = 0; k < 20; k++) begin
      pick = $urandom_range(1, 3);
      r0 = (pick != 2);
      r1 = (pick != 1);
      ra0 = W'($urandom); rb0 = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 255));
      ra1 = W'($urandom); rb1 = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 255));
      do_txn("rand", r0, r1, ra0, rb0, ra1, rb1, $urandom_range(1, 20));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
